// File: rtl/mips_instr_memory_pkg.sv
// ---------------------------------------------------------------------------
// mips_tb_pkg
//   Shared types and constants for the MIPS instruction-memory responder.
//   Contents:
//     imem_state_t  LOAD / RUN / HALTED controller states
//     RESET_VECTOR  byte address the CPU fetches first (word 0 of the store)
//     NOP_WORD      word returned for the end-of-program fetch at address 0
//     bswap32       reverses byte order (natural MIPS word -> CPU bus order)
// ---------------------------------------------------------------------------
package mips_tb_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } imem_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_instr_memory_if.sv
// ---------------------------------------------------------------------------
// mips_instr_memory_if
//   Program-preload port of the instruction memory (valid/ready handshake).
//   Signals:
//     load_valid  master -> slave  a program word is offered
//     load_data   master -> slave  program word, natural MIPS byte order
//     load_last   master -> slave  offered word is the final one
//     load_ready  slave  -> master memory accepts words (LOAD state only)
//   Modports: master (loader / bench), slave (mips_instr_memory).
// ---------------------------------------------------------------------------
interface mips_instr_memory_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (output load_valid, output load_data, output load_last,
                  input  load_ready);
  modport slave  (input  load_valid, input  load_data, input  load_last,
                  output load_ready);
endinterface

// File: rtl/mips_instr_memory_array.sv
// ---------------------------------------------------------------------------
// mips_imem_array
//   DEPTH x 32 program store: one synchronous write port, one asynchronous
//   read port. Contents are deliberately not reset so a program survives a
//   CPU restart. A write and a read of the same word in one cycle return the
//   old contents (the write lands on the clock edge).
//   Ports:
//     clk      clock
//     we_i     write enable
//     waddr_i  write word index
//     wdata_i  write data
//     raddr_i  read word index
//     rdata_o  read data (combinational)
// ---------------------------------------------------------------------------
module mips_imem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_instr_memory.sv
// ---------------------------------------------------------------------------
// mips_instr_memory
//   Instruction-fetch responder for mips_cpu_harvard. Preloads a program over
//   a valid/ready port, holds the CPU in reset until the last word arrives,
//   serves fetches combinationally (byte-swapped), then stops on program end
//   (fetch of address 0 with cpu_active low) or on a RUN-cycle budget and
//   captures $v0.
//   Optional build macro: MIPS_IMEM_BOUNDS_CHECK_EN -- misaligned or
//   out-of-range fetches in RUN return 0 and set a sticky fault. Without it,
//   addresses wrap modulo DEPTH and fault is constant 0.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     load_if         preload port (slave)
//     instr_address   CPU fetch byte address
//     instr_readdata  fetched word, byte-swapped
//     cpu_active      CPU active flag
//     register_v0     CPU $v0
//     cpu_reset       active-high CPU reset (high except in RUN)
//     done, timeout   sticky halt flags
//     result          $v0 captured at halt
//     cycles          RUN cycles, saturating at MAX_CYCLES
//     load_ovf        sticky: word offered while store full
//     fault           sticky bounds fault
// ---------------------------------------------------------------------------
module mips_instr_memory
  import mips_tb_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter logic [31:0] BASE_ADDR  = RESET_VECTOR,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_instr_memory_if.slave         load_if,
  input  logic [31:0]                instr_address,
  output logic [31:0]                instr_readdata,
  input  logic                       cpu_active,
  input  logic [31:0]                register_v0,
  output logic                       cpu_reset,
  output logic                       done,
  output logic                       timeout,
  output logic [31:0]                result,
  output logic [31:0]                cycles,
  output logic                       load_ovf,
  output logic                       fault
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_FULL  = (AW+1)'(DEPTH);
  localparam logic [31:0] MAX32     = 32'(MAX_CYCLES);

  imem_state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] result_q, result_d;
  logic [31:0] cycles_q, cycles_d;
  logic        ovf_q, ovf_d;
  logic        fault_q, fault_d;

  logic [31:0] offset;
  logic [AW-1:0] rd_idx;
  logic [31:0] rd_word;
  logic        ptr_full;
  logic        load_xfer;
  logic        mem_we;
  logic        halt_hit;
  logic        fetch_bad;

  // Offset from the program base; wrapping subtraction makes the word index
  // naturally modulo DEPTH.
  assign offset = instr_address - BASE_ADDR;
  assign rd_idx = offset[AW+1:2];

`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
  // Address 0 is the end-of-program fetch, never a fault.
  assign fetch_bad = (state_q == RUN) && (instr_address != 32'h0) &&
                     ((instr_address[1:0] != 2'b00) ||
                      (offset >= 32'(DEPTH * 4)));
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
  assign fetch_bad = 1'b0;
`endif

  assign ptr_full  = (ptr_q == PTR_FULL);
  assign load_xfer = (state_q == LOAD) && load_if.load_valid;
  assign mem_we    = load_xfer && !ptr_full;
  assign halt_hit  = !cpu_active && (instr_address == 32'h0);

  mips_imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (load_if.load_data),
    .raddr_i (rd_idx),
    .rdata_o (rd_word)
  );

  assign instr_readdata = ((instr_address == 32'h0) || fetch_bad) ? NOP_WORD
                                                                  : bswap32(rd_word);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    ovf_d     = ovf_q;
    fault_d   = fault_q;
    case (state_q)
      LOAD: begin
        if (load_xfer) begin
          if (ptr_full) begin
            ovf_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
          if (load_if.load_last) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (cycles_q != MAX32) begin
          cycles_d = cycles_q + 32'd1;
        end
        if (fetch_bad) begin
          fault_d = 1'b1;
        end
        // Program end wins over the budget check on the same edge.
        if (halt_hit) begin
          result_d = register_v0;
          done_d   = 1'b1;
          state_d  = HALTED;
        end else if (cycles_q == MAX32 - 32'd1) begin
          result_d  = register_v0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = HALTED;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= 32'h0;
      cycles_q  <= 32'h0;
      ovf_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
      ovf_q     <= ovf_d;
      fault_q   <= fault_d;
    end
  end

  assign load_if.load_ready = (state_q == LOAD);
  assign cpu_reset          = (state_q != RUN);
  assign done               = done_q;
  assign timeout            = timeout_q;
  assign result             = result_q;
  assign cycles             = cycles_q;
  assign load_ovf           = ovf_q;
  assign fault              = fault_q;

endmodule

// File: tb/tb_mips_instr_memory.sv
module tb_mips_instr_memory;

  localparam int DEPTH = 8;
  localparam int MAXC  = 20;

  localparam int S_RDATA = 0, S_CPURST = 1, S_READY = 2, S_DONE = 3, S_TOUT = 4,
                 S_RES = 5, S_CYC = 6, S_OVF = 7, S_FAULT = 8, S_HS = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_instr_memory_if lif();
  logic [31:0] instr_address;
  logic        cpu_active;
  logic [31:0] register_v0;
  logic [31:0] instr_readdata, result, cycles;
  logic        cpu_reset, done, timeout, load_ovf, fault;

  mips_instr_memory #(
    .DEPTH      (DEPTH),
    .BASE_ADDR  (32'hBFC0_0000),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_if        (lif),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .cpu_active     (cpu_active),
    .register_v0    (register_v0),
    .cpu_reset      (cpu_reset),
    .done           (done),
    .timeout        (timeout),
    .result         (result),
    .cycles         (cycles),
    .load_ovf       (load_ovf),
    .fault          (fault)
  );

  typedef struct { string name; int sig; logic [31:0] exp; } chk_t;
  typedef struct { logic [31:0] res; logic tout; } done_t;
  chk_t  exp_q[$];
  done_t done_q[$];

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int edges = 0;
  bit done_seen = 0;

`ifdef MIPS_IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] sel(input int s);
    case (s)
      S_RDATA:  return instr_readdata;
      S_CPURST: return {31'h0, cpu_reset};
      S_READY:  return {31'h0, lif.load_ready};
      S_DONE:   return {31'h0, done};
      S_TOUT:   return {31'h0, timeout};
      S_RES:    return result;
      S_CYC:    return cycles;
      S_OVF:    return {31'h0, load_ovf};
      S_FAULT:  return {31'h0, fault};
      default:  return 32'(hs_count);
    endcase
  endfunction

  // Monitor: counts handshakes, drains queued expectations, and checks every
  // rising edge of done against the scoreboard of expected halts.
  always @(negedge clk) begin
    if (lif.load_valid && lif.load_ready) hs_count++;
    while (exp_q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = exp_q.pop_front();
      act = sel(c.sig);
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
    if (done && !done_seen) begin
      done_seen = 1;
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got result %h timeout %b expected no halt", result, timeout);
      end else begin
        done_t d;
        d = done_q.pop_front();
        checks += 2;
        if (result !== d.res) begin
          failures++;
          $display("FAIL halt_result: got %h expected %h", result, d.res);
        end
        if (timeout !== d.tout) begin
          failures++;
          $display("FAIL halt_timeout: got %b expected %b", timeout, d.tout);
        end
      end
    end
    if (!done) done_seen = 0;
  end

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic chk(input string n, input int s, input logic [31:0] e);
    exp_q.push_back('{n, s, e});
  endtask

  task automatic fetch(input string n, input logic [31:0] a, input logic [31:0] e);
    instr_address = a;
    cpu_active = 1'b1;
    chk(n, S_RDATA, e);
    @(negedge clk);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  logic [31:0] prog [4];
  int run_start;
  int halt_cyc;

  initial begin
    prog[0] = 32'h2401_0020; prog[1] = 32'h8C22_0004;
    prog[2] = 32'h3C1D_1234; prog[3] = 32'h03E0_0008;
    lif.load_valid = 0; lif.load_data = 0; lif.load_last = 0;
    instr_address = 32'hBFC0_0000; cpu_active = 1; register_v0 = 0;

    // Reset state
    tick(); tick();
    chk("rst_ready", S_READY, 1);  chk("rst_cpu_reset", S_CPURST, 1);
    chk("rst_done", S_DONE, 0);    chk("rst_timeout", S_TOUT, 0);
    chk("rst_result", S_RES, 0);   chk("rst_cycles", S_CYC, 0);
    chk("rst_ovf", S_OVF, 0);      chk("rst_fault", S_FAULT, 0);
    @(negedge clk);
    reset = 1; tick();

    // Basic load of 4 words, then RUN
    hs_count = 0;
    for (int i = 0; i < 4; i++) begin
      lif.load_valid = 1; lif.load_data = prog[i]; lif.load_last = (i == 3);
      tick();
    end
    lif.load_valid = 0; lif.load_last = 0;
    run_start = edges;
    chk("load_handshakes", S_HS, 4);
    chk("run_cpu_reset", S_CPURST, 0);
    chk("run_ready", S_READY, 0);
    chk("run_cycles0", S_CYC, 0);
    fetch("fetch_w0", 32'hBFC0_0000, 32'h2000_0124);
    fetch("fetch_w1", 32'hBFC0_0004, 32'h0400_228C);
    fetch("fetch_w3", 32'hBFC0_000C, 32'h0800_E003);
    fetch("fetch_addr0_nop", 32'h0000_0000, 32'h0);
    fetch("fetch_wrap", 32'hBFC0_0000 + DEPTH*4, BOUNDS ? 32'h0 : 32'h2000_0124);
    fetch("fetch_misaligned", 32'hBFC0_0002, BOUNDS ? 32'h0 : 32'h2000_0124);
    chk("fault_flag", S_FAULT, BOUNDS ? 32'd1 : 32'd0);
    chk("no_halt_yet", S_DONE, 0);

    // Program end: active low, address 0, $v0 = 32
    cpu_active = 0; instr_address = 0; register_v0 = 32;
    done_q.push_back('{32'd32, 1'b0});
    tick();
    halt_cyc = edges - run_start;
    chk("halt_done", S_DONE, 1);
    chk("halt_cpu_reset", S_CPURST, 1);
    chk("halt_cycles", S_CYC, 32'(halt_cyc));
    cpu_active = 1; register_v0 = 99; instr_address = 32'hBFC0_0004;
    @(negedge clk);
    tick(); tick(); tick();
    chk("frozen_cycles", S_CYC, 32'(halt_cyc));
    chk("frozen_result", S_RES, 32);
    chk("frozen_done", S_DONE, 1);
    @(negedge clk);

    // Overflow: DEPTH+2 words with valid held high
    reset = 0; tick(); reset = 1; tick();
    chk("ovf_pre_done", S_DONE, 0);
    hs_count = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      lif.load_valid = 1; lif.load_data = 32'hA000_0000 + 32'(i);
      lif.load_last = (i == DEPTH + 1);
      tick();
    end
    lif.load_valid = 0; lif.load_last = 0;
    chk("ovf_handshakes", S_HS, DEPTH + 2);
    chk("ovf_flag", S_OVF, 1);
    chk("ovf_run", S_CPURST, 0);
    for (int i = 0; i < DEPTH; i++)
      fetch("ovf_word", 32'hBFC0_0000 + 32'(4 * i), swap(32'hA000_0000 + 32'(i)));
    chk("ovf_no_fault", S_FAULT, 0);

    // Reset asserted mid-RUN
    reset = 0;
    instr_address = 32'hBFC0_0008;
    chk("midrst_cpu_reset", S_CPURST, 1);
    chk("midrst_done", S_DONE, 0);
    chk("midrst_ready", S_READY, 1);
    chk("midrst_ovf", S_OVF, 0);
    chk("midrst_retained", S_RDATA, swap(32'hA000_0002));
    @(negedge clk);
    tick();
    reset = 1; tick();

    // Timeout: one-word program, CPU never ends
    lif.load_valid = 1; lif.load_data = 32'h3C08_ABCD; lif.load_last = 1;
    tick();
    lif.load_valid = 0; lif.load_last = 0;
    cpu_active = 1; instr_address = 32'hBFC0_0004; register_v0 = 32'h55;
    done_q.push_back('{32'h55, 1'b1});
    chk("to_retained_w1", S_RDATA, swap(32'hA000_0001));
    @(negedge clk);
    for (int i = 0; i < MAXC - 1; i++) tick();
    chk("to_not_yet", S_DONE, 0);
    chk("to_cycles19", S_CYC, MAXC - 1);
    @(negedge clk);
    tick();
    chk("to_done", S_DONE, 1);
    chk("to_flag", S_TOUT, 1);
    chk("to_cycles", S_CYC, MAXC);
    chk("to_cpu_reset", S_CPURST, 1);
    @(negedge clk);
    lif.load_valid = 1; lif.load_data = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    lif.load_valid = 0;
    instr_address = 32'hBFC0_0000;
    chk("halted_cycles", S_CYC, MAXC);
    chk("halted_ready", S_READY, 0);
    chk("halted_w0", S_RDATA, 32'hCDAB_083C);
    @(negedge clk);
    tick();
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", exp_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
